// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types and defaults for the pulse stretcher slice.
//   stretch_state_t    : pulse_stretcher FSM encoding
//   STRETCH_CYCLES_DEF : default high period in clk cycles
//   GAP_CYCLES_DEF     : default minimum low gap in clk cycles
//   max_int            : helper used to size the shared down-counter
package mdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GUARD = 2'd2
  } stretch_state_t;

  localparam int STRETCH_CYCLES_DEF = 16;
  localparam int GAP_CYCLES_DEF     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_hold_counter.sv
// pulse_hold_counter: CNT_W-bit down-counter used for both the high period
// and the low gap of pulse_stretcher. Load has priority over decrement, and
// decrement saturates at zero so the count never wraps.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   enb       in   clock enable; low freezes the count
//   sync_rst  in   synchronous clear, active-high, priority over enb
//   load      in   load load_val on the next enabled edge
//   load_val  in   value to load
//   dec       in   decrement by one on the next enabled edge (if nonzero)
//   value     out  current count
//   zero      out  count equals zero (terminal count)
module pulse_hold_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             sync_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (sync_rst) begin
      value <= '0;
    end else if (enb) begin
      if (load) begin
        value <= load_val;
      end else if (dec && (value != '0)) begin
        value <= value - ONE;
      end
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns a single-cycle request pulse into a level held high
// for STRETCH_CYCLES enabled cycles, followed by at least GAP_CYCLES low
// cycles. One pulse arriving during the gap is queued (pending); any further
// pulse that cannot be honoured sets the sticky overrun flag.
//
// Build option: define PULSE_STRETCH_RETRIGGER_EN to let a pulse during the
// high period restart it (level extended). Without it such a pulse is
// dropped and flagged as overrun.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   enb        in   clock enable; low freezes all state, pulse_in ignored
//   sync_rst   in   synchronous clear, active-high, priority over enb
//   pulse_in   in   request pulse
//   level_out  out  stretched level (registered)
//   busy       out  not idle, or a request is pending
//   overrun    out  sticky lost-pulse flag, cleared by rst / sync_rst
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | level low, waiting for a pulse
// ST_HOLD  | level high, counter runs down the remaining high cycles
// ST_GUARD | level low, counter runs down the mandatory gap
module pulse_stretcher
  import mdr_pkg::*;
#(
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic sync_rst,
  input  logic pulse_in,
  output logic level_out,
  output logic busy,
  output logic overrun
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, GAP_CYCLES) + 1);

  // Counter holds "cycles left after this one", hence the -1 on reload.
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);

  stretch_state_t   state, next_state;
  logic             pending, pending_next;
  logic             overrun_q, overrun_next;
  logic             level_q, level_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  pulse_hold_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .sync_rst (sync_rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // State register plus the flags that move with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      level_q   <= 1'b0;
    end else if (sync_rst) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      level_q   <= 1'b0;
    end else if (enb) begin
      state     <= next_state;
      pending   <= pending_next;
      overrun_q <= overrun_next;
      level_q   <= level_next;
    end
  end

  // Next-state logic. The counter is gated by enb on its own, so these
  // controls only take effect on enabled edges.
  always_comb begin
    next_state   = state;
    pending_next = pending;
    overrun_next = overrun_q;
    level_next   = level_q;
    cnt_load     = 1'b0;
    cnt_load_val = STRETCH_LOAD;
    cnt_dec      = 1'b0;

    case (state)
      ST_IDLE: begin
        level_next = 1'b0;
        if (pulse_in) begin
          next_state   = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = STRETCH_LOAD;
          level_next   = 1'b1;
        end
      end

      ST_HOLD: begin
        level_next = 1'b1;
        if (cnt_zero) begin
          next_state   = ST_GUARD;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
          level_next   = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
        // A pulse on the exit edge still counts as a pulse in HOLD, so this
        // overrides the exit decided above.
        if (pulse_in) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          next_state   = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = STRETCH_LOAD;
          cnt_dec      = 1'b0;
          level_next   = 1'b1;
`else
          overrun_next = 1'b1;
`endif
        end
      end

      ST_GUARD: begin
        level_next = 1'b0;
        if (cnt_zero) begin
          if (pending || pulse_in) begin
            // Pending already queued and another pulse arrives: the new one is lost.
            if (pending && pulse_in) begin
              overrun_next = 1'b1;
            end
            next_state   = ST_HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = STRETCH_LOAD;
            pending_next = 1'b0;
            level_next   = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
          if (pulse_in) begin
            if (pending) begin
              overrun_next = 1'b1;
            end else begin
              pending_next = 1'b1;
            end
          end
        end
      end

      default: begin
        next_state = ST_IDLE;
        level_next = 1'b0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    level_out = level_q;
    overrun   = overrun_q;
    busy      = (state != ST_IDLE) || pending;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst, enb, sync_rst, pulse_in;
  logic level4, busy4, ovr4;
  logic level1, busy1, ovr1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.STRETCH_CYCLES(4), .GAP_CYCLES(2)) u_dut4 (
    .clk(clk), .rst(rst), .enb(enb), .sync_rst(sync_rst), .pulse_in(pulse_in),
    .level_out(level4), .busy(busy4), .overrun(ovr4)
  );

  pulse_stretcher #(.STRETCH_CYCLES(1), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .enb(enb), .sync_rst(sync_rst), .pulse_in(pulse_in),
    .level_out(level1), .busy(busy1), .overrun(ovr1)
  );

  // Reference model: high_left = high cycles still to show (including the
  // current one), gap_left = low gap cycles still owed.
  typedef struct {
    int high_left;
    int gap_left;
    bit pend;
    bit ovr;
  } mstate_t;

  mstate_t m4, m1;

  function automatic mstate_t m_clear();
    mstate_t r;
    r.high_left = 0;
    r.gap_left  = 0;
    r.pend      = 1'b0;
    r.ovr       = 1'b0;
    return r;
  endfunction

  function automatic mstate_t m_step(input mstate_t m, input int s, input int g, input bit p);
    mstate_t r = m;
    if (m.high_left > 0) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      if (p) r.high_left = s;
      else begin
        r.high_left = m.high_left - 1;
        if (r.high_left == 0) r.gap_left = g;
      end
`else
      if (p) r.ovr = 1'b1;
      r.high_left = m.high_left - 1;
      if (r.high_left == 0) r.gap_left = g;
`endif
    end else if (m.gap_left > 0) begin
      r.gap_left = m.gap_left - 1;
      if (r.gap_left == 0) begin
        if (m.pend || p) begin
          if (m.pend && p) r.ovr = 1'b1;
          r.high_left = s;
          r.pend      = 1'b0;
        end
      end else if (p) begin
        if (m.pend) r.ovr = 1'b1;
        else r.pend = 1'b1;
      end
    end else if (p) begin
      r.high_left = s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("level4",   {31'd0, level4}, {31'd0, m4.high_left > 0});
    chk("busy4",    {31'd0, busy4},  {31'd0, (m4.high_left > 0) || (m4.gap_left > 0) || m4.pend});
    chk("overrun4", {31'd0, ovr4},   {31'd0, m4.ovr});
    chk("level1",   {31'd0, level1}, {31'd0, m1.high_left > 0});
    chk("busy1",    {31'd0, busy1},  {31'd0, (m1.high_left > 0) || (m1.gap_left > 0) || m1.pend});
    chk("overrun1", {31'd0, ovr1},   {31'd0, m1.ovr});
  endtask

  // Called at a negedge: drive inputs, advance one edge, check at next negedge.
  task automatic step(input bit p, input bit e, input bit sr);
    pulse_in = p;
    enb      = e;
    sync_rst = sr;
    @(posedge clk);
    if (!rst || sr) begin
      m4 = m_clear();
      m1 = m_clear();
    end else if (e) begin
      m4 = m_step(m4, 4, 2, p);
      m1 = m_step(m1, 1, 1, p);
    end
    @(negedge clk);
    check_model();
  endtask

  // Async reset asserted mid-cycle with pulse_in high; outputs must drop at once.
  task automatic async_reset();
    pulse_in = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    m4 = m_clear();
    m1 = m_clear();
    chk("async_level", {31'd0, level4}, 32'd0);
    chk("async_busy",  {31'd0, busy4},  32'd0);
    chk("async_ovr",   {31'd0, ovr4},   32'd0);
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
  endtask

  task automatic run_pattern(input logic [15:0] pul, input logic [15:0] en, input int n,
                             output logic [15:0] lv4, output logic [15:0] bz4,
                             output logic [15:0] lv1, output logic [15:0] bz1);
    lv4 = '0; bz4 = '0; lv1 = '0; bz1 = '0;
    for (int k = 0; k < n; k++) begin
      step(pul[k], en[k], 1'b0);
      lv4[k] = level4;
      bz4[k] = busy4;
      lv1[k] = level1;
      bz1[k] = busy1;
    end
  endtask

  task automatic clear_idle();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] lv4, bz4, lv1, bz1;
    rst = 1'b0; enb = 1'b0; sync_rst = 1'b0; pulse_in = 1'b0;
    m4 = m_clear();
    m1 = m_clear();
    @(negedge clk);
    chk("reset_level", {31'd0, level4}, 32'd0);
    chk("reset_busy",  {31'd0, busy4},  32'd0);
    chk("reset_ovr",   {31'd0, ovr4},   32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // Single pulse: high 4 cycles, busy 6 cycles; 1/1 instance high for one cycle.
    clear_idle();
    run_pattern(16'h0001, 16'hFFFF, 8, lv4, bz4, lv1, bz1);
    chk("single_level", {16'd0, lv4}, 32'h0F);
    chk("single_busy",  {16'd0, bz4}, 32'h3F);
    chk("s1_level",     {16'd0, lv1}, 32'h01);
    chk("s1_busy",      {16'd0, bz1}, 32'h03);

    // Pulse during the gap is queued.
    clear_idle();
    run_pattern(16'h0021, 16'hFFFF, 12, lv4, bz4, lv1, bz1);
    chk("pend_level", {16'd0, lv4}, 32'h3CF);
    chk("pend_busy",  {16'd0, bz4}, 32'hFFF);
    chk("pend_ovr",   {31'd0, ovr4}, 32'd0);

    // Pulse during the high period.
    clear_idle();
    run_pattern(16'h0005, 16'hFFFF, 8, lv4, bz4, lv1, bz1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    chk("hold_level", {16'd0, lv4}, 32'h3F);
    chk("hold_busy",  {16'd0, bz4}, 32'hFF);
    chk("hold_ovr",   {31'd0, ovr4}, 32'd0);
`else
    chk("hold_level", {16'd0, lv4}, 32'h0F);
    chk("hold_busy",  {16'd0, bz4}, 32'h3F);
    chk("hold_ovr",   {31'd0, ovr4}, 32'd1);
`endif

    // enb low for two cycles freezes the count and ignores pulses.
    clear_idle();
    run_pattern(16'h000D, 16'hFFF3, 8, lv4, bz4, lv1, bz1);
    chk("enb_level", {16'd0, lv4}, 32'h3F);
    chk("enb_busy",  {16'd0, bz4}, 32'hFF);
    chk("enb_ovr",   {31'd0, ovr4}, 32'd0);

    // Force an overrun via a second pulse while pending, then sync_rst with enb=0.
    clear_idle();
    run_pattern(16'h0061, 16'hFFFF, 8, lv4, bz4, lv1, bz1);
    chk("dbl_pend_ovr",   {31'd0, ovr4},   32'd1);
    chk("dbl_pend_level", {31'd0, level4}, 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("srst_level", {31'd0, level4}, 32'd0);
    chk("srst_busy",  {31'd0, busy4},  32'd0);
    chk("srst_ovr",   {31'd0, ovr4},   32'd0);

    // Async reset mid-HOLD, then idle until the next pulse.
    clear_idle();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    async_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    chk("post_rst_idle", {31'd0, busy4}, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_pulse", {31'd0, level4}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        async_reset();
      end else begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 85, $urandom_range(0, 199) < 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
